key_debounce_capture: RTL and testbench
=======================================

Name: key_debounce_capture

Overview:
- Parametrised push-button input conditioner for N keys on the board I/O path: 2-flop synchroniser, per-key debounce counter, press-edge capture and maskable interrupt.
- Sits between the board KEY pins and the Nios system bus.
- Provides a small register slave with 1-cycle read latency, so software sees clean levels and latched press events.

Parameters:
- NUM_KEYS, 4, number of key channels (1..32).
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles needed to accept a new level (20 ms at 50 MHz); minimum 2.
- CNT_WIDTH, 20, debounce counter width; must satisfy 2^CNT_WIDTH > DEBOUNCE_CYCLES.
- ACTIVE_LOW, 1, 1 = raw key reads 0 when pressed; the raw input is inverted after synchronisation.

Ports:
- clk_0  in  1  system clock, 50 MHz.
- reset  in  1  synchronous, active-high reset.
- key_in  in  NUM_KEYS  raw asynchronous key pins.
- address  in  2  register select.
- read  in  1  read strobe.
- write  in  1  write strobe.
- writedata  in  32  write data; bits [NUM_KEYS-1:0] used.
- readdata  out  32  registered read data.
- irq  out  1  level interrupt, active high.
- key_level  out  NUM_KEYS  debounced pressed level (1 = pressed), for direct LED use.

Behaviour:
- Reset: sync flops load the inactive raw level (all 1s if ACTIVE_LOW, else 0s), so no spurious event after reset. All of the following clear to 0: counters, key_level, mask, capture, readdata, irq. Reset asserted mid-debounce aborts the count; no event is generated.
- Synchroniser: 2 flops per key; the polarity-corrected value is sync_k.
- Debounce, per key k:
  - If sync_k == key_level_k, cnt_k <= 0.
  - Else cnt_k increments.
  - When cnt_k == DEBOUNCE_CYCLES-1 and the values still differ, key_level_k toggles and cnt_k <= 0.
  - Any bounce back to the stable value restarts the count.
  - Total latency from a pin change to key_level: DEBOUNCE_CYCLES + 2 cycles.
- Press event: key_level_k goes 0->1 -> capture_k <= 1 on the same edge key_level updates.
- Register map, addr : access : meaning:
  - 0 : RO : key_level, zero-extended.
  - 1 : RW : irq mask, bits [NUM_KEYS-1:0]; upper bits read 0.
  - 2 : W1C : press capture. Writing 1 clears the bit; writing 0 has no effect.
  - 3 : see Optional Feature.
- Write/event collision on the same key in the same cycle: the set wins and capture stays 1.
- Read: readdata updates on the clock edge after read=1 (1-cycle latency). When read=0, readdata holds its last value. Simultaneous read and write to the same address returns the pre-write value.
- irq is registered: irq <= |(capture & mask) (plus release terms when the optional feature is enabled). irq rises 1 cycle after capture/mask change and falls 1 cycle after a clear.
- Multiple keys are fully independent; simultaneous presses set all their capture bits in one cycle.
- Counters saturate implicitly: they are reset at the terminal count, so wrap-around cannot occur.

Optional Feature:
- Macro KEY_RELEASE_CAPTURE_EN.
- Defined:
  - Address 3 is a W1C release-capture register, set on key_level 1->0, with the same collision and W1C rules as address 2.
  - The release bits share the mask at address 1, so irq <= |((capture | release) & mask).
- Undefined:
  - Address 3 reads 0 and ignores writes.
  - No release logic is synthesised.

Test Plan (DEBOUNCE_CYCLES=4, NUM_KEYS=4, ACTIVE_LOW=1):
- Reset with key_in=4'hF, hold 10 cycles -> key_level=0, readdata=0, irq=0. Read addr 2 -> 0.
- Drive key_in=4'hE (key0 pressed), hold steady -> key_level=4'h1 exactly 6 cycles after the change. Read addr 2 -> 32'h1. irq stays 0 (mask=0).
- Bounce key0 low/high alternately every 3 cycles for 30 cycles -> key_level unchanged, no capture bit set.
- Write mask=4'h1, press key0 -> irq=1 one cycle after capture. Write 32'h1 to addr 2 -> capture=0 and irq=0 one cycle later. In the same cycle as a new press edge, write a clear -> capture stays 1.
- Press keys 1 and 3 together (key_in=4'h5) -> capture reads 32'hA. Assert reset mid-way through a second press -> all registers return to 0 and no event appears after reset is released.
- With KEY_RELEASE_CAPTURE_EN and mask=4'h1: press then release key0 -> addr 3 reads 32'h1 and irq=1. Without the macro -> addr 3 reads 0.

Source files
------------

// File: rtl/key_debounce_capture.sv
// N-key push-button conditioner: 2-flop sync, per-key debounce, press capture, maskable irq.
// Define KEY_RELEASE_CAPTURE_EN to add the W1C release-capture register at address 3.
module key_debounce_capture #(
  parameter int unsigned NUM_KEYS        = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_WIDTH       = 20,
  parameter int unsigned ACTIVE_LOW      = 1
) (
  input  logic                clk_0,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] key_in,
  input  logic [1:0]          address,
  input  logic                read,
  input  logic                write,
  input  logic [31:0]         writedata,
  output logic [31:0]         readdata,
  output logic                irq,
  output logic [NUM_KEYS-1:0] key_level
);

  localparam logic [NUM_KEYS-1:0]  IDLE_RAW = (ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic [NUM_KEYS-1:0]  sync1_q, sync1_d;
  logic [NUM_KEYS-1:0]  sync2_q, sync2_d;
  logic [NUM_KEYS-1:0]  sync_lvl;
  logic [NUM_KEYS-1:0]  level_q, level_d;
  logic [CNT_WIDTH-1:0] cnt_q [NUM_KEYS];
  logic [CNT_WIDTH-1:0] cnt_d [NUM_KEYS];
  logic [NUM_KEYS-1:0]  mask_q, mask_d;
  logic [NUM_KEYS-1:0]  capture_q, capture_d;
  logic [31:0]          readdata_q, readdata_d;
  logic                 irq_q, irq_d;
  logic [NUM_KEYS-1:0]  wd_keys;
  logic [NUM_KEYS-1:0]  cap_clr;
  logic [31:0]          rd_val;
  logic                 unused_wdata;
`ifdef KEY_RELEASE_CAPTURE_EN
  logic [NUM_KEYS-1:0]  release_q, release_d;
  logic [NUM_KEYS-1:0]  rel_clr;
`endif

  always_comb begin
    sync1_d  = key_in;
    sync2_d  = sync1_q;
    sync_lvl = (ACTIVE_LOW != 0) ? ~sync2_q : sync2_q;

    // Any sample matching the accepted level restarts the count.
    level_d = level_q;
    for (int unsigned k = 0; k < NUM_KEYS; k++) begin
      cnt_d[k] = '0;
      if (sync_lvl[k] != level_q[k]) begin
        if (cnt_q[k] == CNT_LAST) begin
          level_d[k] = ~level_q[k];
        end else begin
          cnt_d[k] = cnt_q[k] + CNT_WIDTH'(1);
        end
      end
    end

    wd_keys      = writedata[NUM_KEYS-1:0];
    unused_wdata = ^writedata;
    cap_clr      = (write && (address == 2'd2)) ? wd_keys : '0;
    mask_d       = (write && (address == 2'd1)) ? wd_keys : mask_q;
    // New events are ORed in after the clear so a same-cycle set wins.
    capture_d    = (capture_q & ~cap_clr) | (level_d & ~level_q);

    rd_val = '0;
    case (address)
      2'd0: rd_val[NUM_KEYS-1:0] = level_q;
      2'd1: rd_val[NUM_KEYS-1:0] = mask_q;
      2'd2: rd_val[NUM_KEYS-1:0] = capture_q;
`ifdef KEY_RELEASE_CAPTURE_EN
      2'd3: rd_val[NUM_KEYS-1:0] = release_q;
`endif
      default: rd_val = '0;
    endcase
    readdata_d = read ? rd_val : readdata_q;

`ifdef KEY_RELEASE_CAPTURE_EN
    rel_clr   = (write && (address == 2'd3)) ? wd_keys : '0;
    release_d = (release_q & ~rel_clr) | (~level_d & level_q);
    irq_d     = |((capture_q | release_q) & mask_q);
`else
    irq_d     = |(capture_q & mask_q);
`endif
  end

  always_ff @(posedge clk_0) begin
    if (reset) begin
      sync1_q    <= IDLE_RAW;
      sync2_q    <= IDLE_RAW;
      level_q    <= '0;
      cnt_q      <= '{default: '0};
      mask_q     <= '0;
      capture_q  <= '0;
      readdata_q <= '0;
      irq_q      <= 1'b0;
`ifdef KEY_RELEASE_CAPTURE_EN
      release_q  <= '0;
`endif
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      level_q    <= level_d;
      cnt_q      <= cnt_d;
      mask_q     <= mask_d;
      capture_q  <= capture_d;
      readdata_q <= readdata_d;
      irq_q      <= irq_d;
`ifdef KEY_RELEASE_CAPTURE_EN
      release_q  <= release_d;
`endif
    end
  end

  assign readdata  = readdata_q;
  assign irq       = irq_q;
  assign key_level = level_q;

endmodule

// File: tb/tb_key_debounce_capture.sv
// Bench for key_debounce_capture with 4 keys, 4-cycle debounce, active-low pins.
module tb_key_debounce_capture;
  localparam int NK = 4;
  localparam int DB = 4;

  logic        clk_0 = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  key_in = 4'hF;
  logic [1:0]  address = 2'd0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] writedata = 32'h0;
  logic [31:0] readdata;
  logic        irq;
  logic [3:0]  key_level;

  int checks = 0;
  int errors = 0;

  always #5 clk_0 = ~clk_0;

  key_debounce_capture #(
    .NUM_KEYS(NK),
    .DEBOUNCE_CYCLES(DB),
    .CNT_WIDTH(3),
    .ACTIVE_LOW(1)
  ) dut (
    .clk_0(clk_0),
    .reset(reset),
    .key_in(key_in),
    .address(address),
    .read(read),
    .write(write),
    .writedata(writedata),
    .readdata(readdata),
    .irq(irq),
    .key_level(key_level)
  );

  // Reference model: pins seen two cycles late, level accepted after DB differing samples in a row.
  bit [3:0]  m_raw1, m_raw2, m_level, m_mask, m_cap, m_rel;
  bit [3:0]  n_level, n_pressed, n_clr, n_rclr;
  bit [31:0] m_rd, n_rd;
  bit        m_irq;
  int        streak [NK];

  always @(posedge clk_0) begin
    if (reset) begin
      m_raw1 = 4'hF; m_raw2 = 4'hF;
      m_level = '0; m_mask = '0; m_cap = '0; m_rel = '0; m_rd = '0; m_irq = 1'b0;
      for (int k = 0; k < NK; k++) streak[k] = 0;
    end else begin
      n_pressed = ~m_raw2;
      n_level   = m_level;
      for (int k = 0; k < NK; k++) begin
        if (n_pressed[k] != m_level[k]) begin
          streak[k] = streak[k] + 1;
          if (streak[k] == DB) begin
            n_level[k] = ~m_level[k];
            streak[k]  = 0;
          end
        end else begin
          streak[k] = 0;
        end
      end
      case (address)
        2'd0: n_rd = {28'h0, m_level};
        2'd1: n_rd = {28'h0, m_mask};
        2'd2: n_rd = {28'h0, m_cap};
        default: n_rd = {28'h0, m_rel};
      endcase
      m_irq  = |((m_cap | m_rel) & m_mask);
      if (read) m_rd = n_rd;
      n_clr  = (write && address == 2'd2) ? writedata[3:0] : 4'h0;
      n_rclr = (write && address == 2'd3) ? writedata[3:0] : 4'h0;
      m_cap  = (m_cap & ~n_clr) | (n_level & ~m_level);
`ifdef KEY_RELEASE_CAPTURE_EN
      m_rel  = (m_rel & ~n_rclr) | (~n_level & m_level);
`endif
      if (write && address == 2'd1) m_mask = writedata[3:0];
      m_level = n_level;
      m_raw2  = m_raw1;
      m_raw1  = key_in;
    end
  end

  task automatic do_write(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; write = 1'b1;
    @(negedge clk_0);
    write = 1'b0;
  endtask

  task automatic do_read(input logic [1:0] a, output logic [31:0] d);
    address = a; read = 1'b1;
    @(negedge clk_0);
    read = 1'b0;
    d = readdata;
  endtask

  task automatic test_reset;
    logic [31:0] d;
    reset = 1'b1; key_in = 4'hF;
    repeat (10) @(negedge clk_0);
    reset = 1'b0;
    @(negedge clk_0);
    checks++;
    if (key_level !== 4'h0 || readdata !== 32'h0 || irq !== 1'b0) begin
      errors++;
      $display("FAIL reset_state level=%h rd=%h irq=%b exp 0/0/0", key_level, readdata, irq);
    end
    do_read(2'd2, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL reset_capture got %h exp 0", d); end
  endtask

  task automatic test_press_latency;
    logic [31:0] d;
    key_in = 4'hE;
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk_0);
      checks++;
      if (key_level !== ((i >= 6) ? 4'h1 : 4'h0)) begin
        errors++;
        $display("FAIL press_latency cycle %0d got %h exp %h", i, key_level, (i >= 6) ? 4'h1 : 4'h0);
      end
    end
    do_read(2'd2, d);
    checks++;
    if (d !== 32'h1) begin errors++; $display("FAIL press_capture got %h exp 1", d); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL masked_irq got %b exp 0", irq); end
  endtask

  task automatic test_bounce;
    logic [31:0] d;
    do_write(2'd2, 32'hF);
    do_write(2'd3, 32'hF);
    for (int i = 0; i < 10; i++) begin
      key_in[0] = ~key_in[0];
      repeat (3) begin
        @(negedge clk_0);
        checks++;
        if (key_level !== 4'h1) begin errors++; $display("FAIL bounce_level got %h exp 1", key_level); end
      end
    end
    repeat (4) @(negedge clk_0);
    do_read(2'd2, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL bounce_capture got %h exp 0", d); end
    do_read(2'd3, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL bounce_release got %h exp 0", d); end
  endtask

  task automatic test_irq_mask;
    logic [31:0] d;
    do_write(2'd1, 32'h1);
    key_in = 4'hF;
    repeat (8) @(negedge clk_0);
    do_write(2'd3, 32'hF);
    do_write(2'd2, 32'hF);
    repeat (2) @(negedge clk_0);
    key_in = 4'hE;
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk_0);
      checks++;
      if (irq !== (i >= 7)) begin errors++; $display("FAIL irq_rise cycle %0d got %b exp %b", i, irq, i >= 7); end
    end
    do_write(2'd2, 32'h1);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL irq_hold got %b exp 1", irq); end
    @(negedge clk_0);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_fall got %b exp 0", irq); end
    // Clear lands on the same edge the new press is accepted.
    key_in = 4'hF;
    repeat (8) @(negedge clk_0);
    do_write(2'd3, 32'hF);
    key_in = 4'hE;
    repeat (5) @(negedge clk_0);
    do_write(2'd2, 32'h1);
    do_read(2'd2, d);
    checks++;
    if (d !== 32'h1) begin errors++; $display("FAIL collision got %h exp 1", d); end
    checks++;
    if (d !== m_rd) begin errors++; $display("FAIL collision_model got %h exp %h", d, m_rd); end
  endtask

  task automatic test_multi_and_reset;
    logic [31:0] d;
    key_in = 4'hF;
    repeat (8) @(negedge clk_0);
    do_write(2'd2, 32'hF);
    do_write(2'd3, 32'hF);
    key_in = 4'h5;
    repeat (8) @(negedge clk_0);
    do_read(2'd2, d);
    checks++;
    if (d !== 32'hA) begin errors++; $display("FAIL multi_capture got %h exp A", d); end
    checks++;
    if (key_level !== 4'hA) begin errors++; $display("FAIL multi_level got %h exp A", key_level); end
    key_in = 4'hF;
    repeat (8) @(negedge clk_0);
    key_in = 4'h5;
    repeat (3) @(negedge clk_0);
    reset = 1'b1;
    key_in = 4'hF;
    repeat (3) @(negedge clk_0);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_0);
      checks++;
      if (key_level !== 4'h0 || irq !== 1'b0) begin
        errors++;
        $display("FAIL post_reset level=%h irq=%b exp 0/0", key_level, irq);
      end
    end
    for (int a = 0; a < 4; a++) begin
      do_read(2'(a), d);
      checks++;
      if (d !== 32'h0) begin errors++; $display("FAIL post_reset_reg%0d got %h exp 0", a, d); end
    end
  endtask

  task automatic test_release;
    logic [31:0] d;
    do_write(2'd1, 32'h1);
    key_in = 4'hE;
    repeat (8) @(negedge clk_0);
    do_write(2'd2, 32'h1);
    do_write(2'd3, 32'hF);
    key_in = 4'hF;
    repeat (8) @(negedge clk_0);
    do_read(2'd3, d);
`ifdef KEY_RELEASE_CAPTURE_EN
    checks++;
    if (d !== 32'h1) begin errors++; $display("FAIL release_capture got %h exp 1", d); end
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL release_irq got %b exp 1", irq); end
`else
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL addr3_zero got %h exp 0", d); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL release_irq got %b exp 0", irq); end
`endif
  endtask

  task automatic test_random;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk_0);
      checks++;
      if (key_level !== m_level || irq !== m_irq || readdata !== m_rd) begin
        errors++;
        $display("FAIL random cyc %0d level=%h/%h irq=%b/%b rd=%h/%h (got/exp)",
                 i, key_level, m_level, irq, m_irq, readdata, m_rd);
      end
      for (int k = 0; k < NK; k++)
        if ($urandom_range(0, 9) == 0) key_in[k] = ~key_in[k];
      reset     = ($urandom_range(0, 599) == 0);
      read      = $urandom_range(0, 1) == 1;
      write     = $urandom_range(0, 3) == 0;
      address   = 2'($urandom_range(0, 3));
      writedata = $urandom;
    end
    read = 1'b0; write = 1'b0; reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_press_latency();
    test_bounce();
    test_irq_mask();
    test_multi_and_reset();
    test_release();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
